// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: step modes and bounce direction.
package univ_shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'd0,
    MODE_SHL    = 3'd1,
    MODE_SHR    = 3'd2,
    MODE_ROL    = 3'd3,
    MODE_ROR    = 3'd4,
    MODE_BOUNCE = 3'd5
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/univ_shift_reg_prescaler.sv
// Step prescaler: emits a one-cycle step strobe every div_i+1 enabled cycles.
module shift_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] count_q;
  logic                 step;

  // >= rather than == so a lowered div_i expires a long count at once
  always_comb begin
    step   = en_i && !clr_i && (count_q >= div_i);
    tick_o = step;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (step) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with prescaled stepping, parallel load and serial in/out.
// Define UNIV_SHIFT_REG_BOUNCE_EN to build BOUNCE mode and its direction register.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int                  WIDTH      = 9,
  parameter logic [WIDTH-1:0]    INIT_VALUE = WIDTH'(1),
  parameter int                  DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [2:0]           mode_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 load_i,
  input  logic [WIDTH-1:0]     load_data_i,
  input  logic                 ser_lsb_i,
  input  logic                 ser_msb_i,
  output logic [WIDTH-1:0]     reg_out_o,
  output logic                 ser_out_o,
  output logic                 tick_o,
  output logic                 wrap_o
);

  // Handshake: none; step is an internal strobe, tick_o/wrap_o are registered pulses.
  logic             step;
  logic [WIDTH-1:0] reg_q, nxt_reg;
  logic             ser_q, nxt_ser;
  logic             tick_q;
  logic             wrap_q, nxt_wrap;

  shift_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (load_i),
    .en_i   (en_i),
    .div_i  (div_i),
    .tick_o (step)
  );

`ifdef UNIV_SHIFT_REG_BOUNCE_EN
  dir_e dir_q, nxt_dir;
`endif

  always_comb begin
    nxt_reg  = reg_q;
    nxt_ser  = ser_q;
    nxt_wrap = 1'b0;
`ifdef UNIV_SHIFT_REG_BOUNCE_EN
    nxt_dir  = dir_q;
`endif
    case (mode_i)
      MODE_SHL: begin
        nxt_reg  = {reg_q[WIDTH-2:0], ser_lsb_i};
        nxt_ser  = reg_q[WIDTH-1];
        nxt_wrap = reg_q[WIDTH-1];
      end
      MODE_SHR: begin
        nxt_reg  = {ser_msb_i, reg_q[WIDTH-1:1]};
        nxt_ser  = reg_q[0];
        nxt_wrap = reg_q[0];
      end
      MODE_ROL: begin
        nxt_reg  = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        nxt_ser  = reg_q[WIDTH-1];
        nxt_wrap = reg_q[WIDTH-1];
      end
      MODE_ROR: begin
        nxt_reg  = {reg_q[0], reg_q[WIDTH-1:1]};
        nxt_ser  = reg_q[0];
        nxt_wrap = reg_q[0];
      end
`ifdef UNIV_SHIFT_REG_BOUNCE_EN
      MODE_BOUNCE: begin
        // Only the end we are heading towards can trigger a reversal
        if (dir_q == DIR_LEFT && reg_q[WIDTH-1]) begin
          nxt_dir  = DIR_RIGHT;
          nxt_wrap = 1'b1;
          nxt_reg  = {1'b0, reg_q[WIDTH-1:1]};
          nxt_ser  = reg_q[0];
        end else if (dir_q == DIR_RIGHT && reg_q[0]) begin
          nxt_dir  = DIR_LEFT;
          nxt_wrap = 1'b1;
          nxt_reg  = {reg_q[WIDTH-2:0], 1'b0};
          nxt_ser  = reg_q[WIDTH-1];
        end else if (dir_q == DIR_LEFT) begin
          nxt_reg  = {reg_q[WIDTH-2:0], 1'b0};
          nxt_ser  = reg_q[WIDTH-1];
        end else begin
          nxt_reg  = {1'b0, reg_q[WIDTH-1:1]};
          nxt_ser  = reg_q[0];
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q  <= INIT_VALUE;
      ser_q  <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (load_i) begin
      reg_q  <= load_data_i;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (step) begin
      reg_q  <= nxt_reg;
      ser_q  <= nxt_ser;
      tick_q <= 1'b1;
      wrap_q <= nxt_wrap;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

`ifdef UNIV_SHIFT_REG_BOUNCE_EN
  always_ff @(posedge clk) begin
    if (rst || load_i) begin
      dir_q <= DIR_LEFT;
    end else if (step) begin
      dir_q <= nxt_dir;
    end
  end
`endif

  assign reg_out_o = reg_q;
  assign ser_out_o = ser_q;
  assign tick_o    = tick_q;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed scoreboard bench for univ_shift_reg (WIDTH=9, INIT 9'h001, DIV_WIDTH=16).
module tb_univ_shift_reg;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic [2:0]  mode_i;
  logic [15:0] div_i;
  logic        load_i;
  logic [8:0]  load_data_i;
  logic        ser_lsb_i;
  logic        ser_msb_i;
  logic [8:0]  reg_out_o;
  logic        ser_out_o;
  logic        tick_o;
  logic        wrap_o;

  // Expected entry layout: {reg[8:0], ser, tick, wrap}
  logic [11:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          failures;

  univ_shift_reg #(.WIDTH(9), .INIT_VALUE(9'h001), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .mode_i      (mode_i),
    .div_i       (div_i),
    .load_i      (load_i),
    .load_data_i (load_data_i),
    .ser_lsb_i   (ser_lsb_i),
    .ser_msb_i   (ser_msb_i),
    .reg_out_o   (reg_out_o),
    .ser_out_o   (ser_out_o),
    .tick_o      (tick_o),
    .wrap_o      (wrap_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: inputs are set beforehand; the expectation is for the edge just taken
  task automatic cyc(input string nm, input logic [8:0] r, input logic s,
                     input logic t, input logic w);
    @(posedge clk);
    exp_q.push_back({r, s, t, w});
    name_q.push_back(nm);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if ({reg_out_o, ser_out_o, tick_o, wrap_o} !== e) begin
        failures++;
        $display("FAIL %s: got reg=%h ser=%b tick=%b wrap=%b, want reg=%h ser=%b tick=%b wrap=%b",
                 nm, reg_out_o, ser_out_o, tick_o, wrap_o, e[11:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic [8:0] e;
    checks = 0; failures = 0;
    rst = 1'b1; en_i = 1'b0; mode_i = 3'd0; div_i = 16'd0; load_i = 1'b0;
    load_data_i = 9'h000; ser_lsb_i = 1'b0; ser_msb_i = 1'b0;

    for (int i = 0; i < 3; i++) cyc("reset", 9'h001, 1'b0, 1'b0, 1'b0);

    // ROL every cycle: walk to the msb, then carry back to bit 0
    rst = 1'b0; en_i = 1'b1; mode_i = 3'd3; div_i = 16'd0;
    for (int i = 1; i <= 8; i++) begin
      e = 9'(1) << i;
      cyc("rol_walk", e, 1'b0, 1'b1, 1'b0);
    end
    cyc("rol_carry", 9'h001, 1'b1, 1'b1, 1'b1);

    // div_i=3: tick every 4th enabled cycle, en_i low delays it
    div_i = 16'd3;
    for (int i = 0; i < 3; i++) cyc("div3_wait", 9'h001, 1'b1, 1'b0, 1'b0);
    cyc("div3_tick", 9'h002, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc("div3_cnt", 9'h002, 1'b0, 1'b0, 1'b0);
    en_i = 1'b0;
    for (int i = 0; i < 2; i++) cyc("en_low", 9'h002, 1'b0, 1'b0, 1'b0);
    en_i = 1'b1;
    cyc("en_resume", 9'h002, 1'b0, 1'b0, 1'b0);
    cyc("delayed_tick", 9'h004, 1'b0, 1'b1, 1'b0);

    // Load on a cycle where a step would fire
    div_i = 16'd0; load_i = 1'b1; load_data_i = 9'h1A5;
    cyc("load", 9'h1A5, 1'b0, 1'b0, 1'b0);
    load_i = 1'b0; mode_i = 3'd1; ser_lsb_i = 1'b1;
    cyc("shl", 9'h14B, 1'b1, 1'b1, 1'b1);
    mode_i = 3'd2; ser_msb_i = 1'b0;
    cyc("shr", 9'h0A5, 1'b1, 1'b1, 1'b1);
    mode_i = 3'd4;
    cyc("ror", 9'h152, 1'b1, 1'b1, 1'b1);
    mode_i = 3'd0;
    cyc("hold", 9'h152, 1'b1, 1'b1, 1'b0);
    mode_i = 3'd6;
    cyc("mode6_hold", 9'h152, 1'b1, 1'b1, 1'b0);
    en_i = 1'b0;
    cyc("disabled", 9'h152, 1'b1, 1'b0, 1'b0);

    // Lowering div_i mid-count expires immediately
    en_i = 1'b1; mode_i = 3'd3; div_i = 16'd5;
    for (int i = 0; i < 2; i++) cyc("div5_cnt", 9'h152, 1'b1, 1'b0, 1'b0);
    div_i = 16'd1;
    cyc("div_lowered", 9'h0A5, 1'b1, 1'b1, 1'b1);

`ifdef UNIV_SHIFT_REG_BOUNCE_EN
    rst = 1'b1; div_i = 16'd0;
    cyc("bounce_rst", 9'h001, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; mode_i = 3'd5;
    for (int i = 1; i <= 8; i++) begin
      e = 9'(1) << i;
      cyc("bounce_left", e, 1'b0, 1'b1, 1'b0);
    end
    cyc("bounce_rev_r", 9'h080, 1'b0, 1'b1, 1'b1);
    for (int i = 10; i <= 16; i++) begin
      e = 9'h100 >> (i - 8);
      cyc("bounce_right", e, 1'b0, 1'b1, 1'b0);
    end
    cyc("bounce_rev_l", 9'h002, 1'b0, 1'b1, 1'b1);

    // Reset while heading right must restore direction LEFT
    rst = 1'b1;
    cyc("bounce_rst2", 9'h001, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      e = 9'(1) << i;
      cyc("bounce_setup", e, 1'b0, 1'b1, 1'b0);
    end
    cyc("bounce_setup_rev", 9'h080, 1'b0, 1'b1, 1'b1);
    cyc("bounce_setup", 9'h040, 1'b0, 1'b1, 1'b0);
    cyc("bounce_setup", 9'h020, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("mid_rst", 9'h001, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      e = 9'(1) << i;
      cyc("post_rst_left", e, 1'b0, 1'b1, 1'b0);
    end

    // All-zero pattern: shifts zeros, never reverses
    load_i = 1'b1; load_data_i = 9'h000;
    cyc("load_zero", 9'h000, 1'b0, 1'b0, 1'b0);
    load_i = 1'b0;
    for (int i = 0; i < 2; i++) cyc("bounce_zero", 9'h000, 1'b0, 1'b1, 1'b0);
`else
    rst = 1'b1; div_i = 16'd0;
    cyc("mode5_rst", 9'h001, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; mode_i = 3'd5;
    for (int i = 0; i < 3; i++) cyc("mode5_hold", 9'h001, 1'b0, 1'b1, 1'b0);
    mode_i = 3'd3;
    cyc("rol_a", 9'h002, 1'b0, 1'b1, 1'b0);
    cyc("rol_b", 9'h004, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("mid_rst", 9'h001, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("post_rst_rol", 9'h002, 1'b0, 1'b1, 1'b0);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with a step prescaler, for running-light and digit-scan patterns in the clock demo. It shifts, rotates or bounces a WIDTH-bit pattern once per programmable step interval and supports parallel load and serial in/out. It drives LED or digit-select lines directly, or feeds a downstream decoder.

## Interface
- WIDTH, 9: register width, ≥ 2.
- INIT_VALUE, 9'h001: value of reg_out_o after reset.
- DIV_WIDTH, 16: width of the prescaler count and of div_i.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en_i  input  1  prescaler count enable; low freezes the prescaler and all stepping.
- mode_i  input  3  step mode: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 BOUNCE, 6–7 act as HOLD.
- div_i  input  DIV_WIDTH  step interval minus one; 0 steps on every enabled cycle.
- load_i  input  1  synchronous parallel load.
- load_data_i  input  WIDTH  load value.
- ser_lsb_i  input  1  bit shifted into bit 0 in SHL.
- ser_msb_i  input  1  bit shifted into bit WIDTH-1 in SHR.
- reg_out_o  output  WIDTH  register contents.
- ser_out_o  output  1  last bit that left the register.
- tick_o  output  1  one-cycle pulse on each step.
- wrap_o  output  1  one-cycle pulse on end-carry or bounce reversal.

## Operation
- Priority per edge: rst > load_i > step > hold.
- rst: reg_out_o=INIT_VALUE, prescaler=0, bounce direction=LEFT, ser_out_o=0, tick_o=0, wrap_o=0.
- load_i: reg_out_o=load_data_i, prescaler=0, direction=LEFT, tick_o=0, wrap_o=0. ser_out_o holds. en_i is ignored that cycle.
- Prescaler: when en_i=1 and no load, if count ≥ div_i then step and count←0, else count←count+1. The ≥ compare lets a lowered div_i take effect immediately.
- Step: tick_o=1 for that cycle, whatever the mode.
  - SHL: out=msb, reg←{reg[W-2:0],ser_lsb_i}.
  - SHR: out=lsb, reg←{ser_msb_i,reg[W-1:1]}.
  - ROL: out=msb, reg←{reg[W-2:0],msb}.
  - ROR: out=lsb, reg←{lsb,reg[W-1:1]}.
  - In SHL, SHR, ROL and ROR, ser_out_o←out and wrap_o←out.
- BOUNCE, zero fill, direction state LEFT/RIGHT:
  - If LEFT and msb=1: direction←RIGHT, shift right, wrap_o=1.
  - If RIGHT and lsb=1: direction←LEFT, shift left, wrap_o=1.
  - Otherwise shift in the current direction, wrap_o=0.
  - Only the current direction's end is checked. An all-zero register shifts zeros with no reversal.
  - ser_out_o takes the bit shifted out.
- HOLD, or a step in modes 6–7: reg_out_o and ser_out_o unchanged, wrap_o=0, tick_o=1.
- A mode_i change takes effect at the next step. The prescaler and direction are not cleared by it.
- A mid-operation rst, on any cycle, restores the full reset state on the next edge.

## Timing
- All outputs are registered and change only on the clk edge.
- Step latency: reg_out_o updates on the edge where the prescaler expires. Step interval is div_i+1 enabled cycles.
- tick_o and wrap_o are high exactly one cycle, on the edge where reg_out_o changes.
- Load: reg_out_o equals load_data_i one cycle after load_i is sampled. The first step follows div_i+1 enabled cycles later.
- en_i low for N cycles delays the next step by N cycles.

## Configuration
- UNIV_SHIFT_REG_BOUNCE_EN defined: BOUNCE mode and the direction register are present.
- Not defined: mode 5 behaves as HOLD, no direction state exists, and wrap_o is driven only by SHL/SHR/ROL/ROR.

## Structure
- Package univ_shift_reg_pkg holds:
  - mode enum (MODE_HOLD … MODE_BOUNCE, 3 bits);
  - direction encoding DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module shift_prescaler:
  - parameter DIV_WIDTH; ports clk, rst, clr_i, en_i, div_i, tick_o;
  - clr_i is driven by load_i.
- Shift/rotate/bounce datapath and output registers stay in the top module.

## Test plan
- Reset, WIDTH=9, INIT 9'h001: reg_out_o=0x001, ser_out_o=0, tick_o=0, wrap_o=0, all held while rst=1.
- ROL, div_i=0, en_i=1: 0x001→0x002→…→0x100 in 8 cycles. The 9th step gives 0x001 with wrap_o=1 and ser_out_o=1.
- div_i=3, ROL: tick_o every 4th enabled cycle. Drop en_i 2 cycles mid-count: the next tick is 2 cycles later.
- Load 0x1A5 on a step cycle: reg_out_o=0x1A5, no tick. Then SHL with ser_lsb_i=1: 0x14B, ser_out_o=1, wrap_o=1.
- BOUNCE from 0x001, div_i=0: 0x100 after 8 steps. Step 9 gives 0x080 with wrap_o=1. Step 16 returns 0x001. Step 17 gives 0x002 with wrap_o=1.
- rst asserted mid-BOUNCE while direction=RIGHT: next edge gives 0x001 and direction LEFT. The following 8 steps walk left to 0x100.
